// File: rtl/rs_intake_queue.sv
// Reservation-station intake queue: filters a two-wide dispatch bundle by station id,
// buffers matching uops in program order and issues them one per cycle (show-ahead).
module rs_intake_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [3:0]  STATION_ID = 4'd1,
  parameter int unsigned UOP_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid0,
  input  logic [3:0]                   in_station0,
  input  logic [UOP_W-1:0]             in_uop0,
  input  logic                         in_valid1,
  input  logic [3:0]                   in_station1,
  input  logic [UOP_W-1:0]             in_uop1,
  output logic                         stall,
  output logic                         issue_valid,
  output logic [UOP_W-1:0]             issue_uop,
  input  logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  accept_total
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    tail_p1;
  logic             match0;
  logic             match1;
  logic             wr_en;
  logic             wr0;
  logic             wr1;
  logic             pop;
  logic [1:0]       n_wr;
  logic [CW-1:0]    count_next;

  // Write/pop decisions; stall is a pure function of registered state.
  always_comb begin
    match0     = in_valid0 && (in_station0 == STATION_ID) && (in_station0 != 4'd0);
    match1     = in_valid1 && (in_station1 == STATION_ID) && (in_station1 != 4'd0);
    wr_en      = !stall && !flush && !reset;
    wr0        = wr_en && match0;
    wr1        = wr_en && match1;
    n_wr       = 2'(wr0) + 2'(wr1);
    pop        = issue_valid && issue_ready && !flush;
    tail_p1    = tail + PW'(1);
    count_next = count + CW'(n_wr) - CW'(pop);
  end

  assign issue_uop = mem[head];

  // Control state; stall and issue_valid are registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall        <= 1'b0;
      issue_valid  <= 1'b0;
      accept_total <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      stall       <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      head         <= head + PW'(pop);
      tail         <= tail + PW'(n_wr);
      count        <= count_next;
      stall        <= count_next > CW'(DEPTH - 2);
      issue_valid  <= count_next != '0;
      accept_total <= accept_total + 32'(n_wr);
    end
  end

  // Storage: slot 0 lands at tail, slot 1 right behind it (or at tail if slot 0 dropped).
  always_ff @(posedge clk) begin
    if (wr0) mem[tail] <= in_uop0;
    if (wr1) mem[wr0 ? tail_p1 : tail] <= in_uop1;
  end

endmodule

// File: tb/tb_rs_intake_queue.sv
// Bench for rs_intake_queue: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_rs_intake_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam logic [3:0]  ST    = 4'd1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid0;
  logic [3:0]    in_station0;
  logic [31:0]   in_uop0;
  logic          in_valid1;
  logic [3:0]    in_station1;
  logic [31:0]   in_uop1;
  logic          stall;
  logic          issue_valid;
  logic [31:0]   issue_uop;
  logic          issue_ready;
  logic [CW-1:0] count;
  logic [31:0]   accept_total;

  rs_intake_queue #(.DEPTH(DEPTH), .STATION_ID(ST), .UOP_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid0(in_valid0), .in_station0(in_station0), .in_uop0(in_uop0),
    .in_valid1(in_valid1), .in_station1(in_station1), .in_uop1(in_uop1),
    .stall(stall), .issue_valid(issue_valid), .issue_uop(issue_uop),
    .issue_ready(issue_ready), .count(count), .accept_total(accept_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of accepted uops plus an acceptance counter.
  logic [31:0] mq[$];
  logic [31:0] m_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic fl,
                            input logic v0, input logic [3:0] s0, input logic [31:0] u0,
                            input logic v1, input logic [3:0] s1, input logic [31:0] u1,
                            input logic rdy);
    bit full_ish;
    if (rst) begin
      mq.delete();
      m_total = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      full_ish = (DEPTH - mq.size()) < 2;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!full_ish) begin
        if (v0 && s0 == ST && s0 != 0) begin mq.push_back(u0); m_total++; end
        if (v1 && s1 == ST && s1 != 0) begin mq.push_back(u1); m_total++; end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and settle just after the edge.
  task automatic apply(input logic rst, input logic fl,
                       input logic v0, input logic [3:0] s0, input logic [31:0] u0,
                       input logic v1, input logic [3:0] s1, input logic [31:0] u1,
                       input logic rdy);
    reset = rst; flush = fl;
    in_valid0 = v0; in_station0 = s0; in_uop0 = u0;
    in_valid1 = v1; in_station1 = s1; in_uop1 = u1;
    issue_ready = rdy;
    model_step(rst, fl, v0, s0, u0, v1, s1, u1, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_valid", 32'(issue_valid), 32'(mq.size() != 0));
    chk("m_stall", 32'(stall), 32'((DEPTH - mq.size()) < 2));
    chk("m_total", accept_total, m_total);
    if (mq.size() != 0) chk("m_uop", issue_uop, mq[0]);
  endtask

  // Occupancy invariant, checked on every falling edge.
  always @(negedge clk) begin
    total++;
    if (count > CW'(DEPTH)) begin
      bad++;
      $display("FAIL occupancy: count %0d exceeds %0d", count, DEPTH);
    end
  end

  typedef struct {
    logic        fl;
    logic        v0;
    logic [3:0]  s0;
    logic [31:0] u0;
    logic        v1;
    logic [3:0]  s1;
    logic [31:0] u1;
    logic        rdy;
    int          e_cnt;
    logic        e_val;
    logic        e_st;
    logic [31:0] e_uop;
    int          e_tot;
  } vec_t;

  function automatic vec_t mk(logic fl, logic v0, logic [3:0] s0, logic [31:0] u0,
                              logic v1, logic [3:0] s1, logic [31:0] u1, logic rdy,
                              int e_cnt, logic e_val, logic e_st, logic [31:0] e_uop, int e_tot);
    vec_t v;
    v.fl = fl; v.v0 = v0; v.s0 = s0; v.u0 = u0; v.v1 = v1; v.s1 = s1; v.u1 = u1; v.rdy = rdy;
    v.e_cnt = e_cnt; v.e_val = e_val; v.e_st = e_st; v.e_uop = e_uop; v.e_tot = e_tot;
    return v;
  endfunction

  vec_t tv[20];

  initial begin
    int idx;
    int popped;
    int cyc;
    int w;
    logic [3:0] smap[4];
    smap[0] = 4'd0; smap[1] = 4'd1; smap[2] = 4'd1; smap[3] = 4'd2;

    tv[0]  = mk(0, 1,1,32'hA1, 1,2,32'hFF, 0,  1,1,0,32'hA1, 1);
    tv[1]  = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  0,0,0,32'h0,  1);
    tv[2]  = mk(0, 1,1,32'hB0, 1,1,32'hB1, 1,  2,1,0,32'hB0, 3);
    tv[3]  = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  1,1,0,32'hB1, 3);
    tv[4]  = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  0,0,0,32'h0,  3);
    tv[5]  = mk(0, 1,0,32'h99, 0,1,32'h98, 0,  0,0,0,32'h0,  3);
    tv[6]  = mk(0, 1,1,32'hC0, 1,1,32'hC1, 0,  2,1,0,32'hC0, 5);
    tv[7]  = mk(0, 1,1,32'hC2, 1,1,32'hC3, 0,  4,1,0,32'hC0, 7);
    tv[8]  = mk(0, 1,1,32'hC4, 1,1,32'hC5, 0,  6,1,0,32'hC0, 9);
    tv[9]  = mk(0, 1,1,32'hC6, 1,1,32'hC7, 0,  8,1,1,32'hC0, 11);
    tv[10] = mk(0, 1,1,32'hD0, 1,1,32'hD1, 0,  8,1,1,32'hC0, 11);
    tv[11] = mk(0, 1,1,32'hD0, 1,1,32'hD1, 1,  7,1,1,32'hC1, 11);
    tv[12] = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  6,1,0,32'hC2, 11);
    tv[13] = mk(0, 1,1,32'hE0, 1,1,32'hE1, 1,  7,1,1,32'hC3, 13);
    tv[14] = mk(0, 0,0,32'h0,  0,0,32'h0,  0,  7,1,1,32'hC3, 13);
    tv[15] = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  6,1,0,32'hC4, 13);
    tv[16] = mk(0, 0,0,32'h0,  0,0,32'h0,  1,  5,1,0,32'hC5, 13);
    tv[17] = mk(1, 1,1,32'hF0, 1,1,32'hF1, 1,  0,0,0,32'h0,  13);
    tv[18] = mk(0, 1,1,32'h60, 0,0,32'h0,  0,  1,1,0,32'h60, 14);
    tv[19] = mk(0, 0,1,32'h5A, 1,1,32'h61, 0,  2,1,0,32'h60, 15);

    apply(1, 0, 0,0,0, 0,0,0, 0);
    apply(1, 0, 0,0,0, 0,0,0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_total", accept_total, 0);

    foreach (tv[i]) begin
      apply(0, tv[i].fl, tv[i].v0, tv[i].s0, tv[i].u0, tv[i].v1, tv[i].s1, tv[i].u1, tv[i].rdy);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d_valid", i), 32'(issue_valid), 32'(tv[i].e_val));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].e_st));
      chk($sformatf("v%0d_total", i), accept_total, 32'(tv[i].e_tot));
      if (tv[i].e_val) chk($sformatf("v%0d_uop", i), issue_uop, tv[i].e_uop);
    end

    // Wrap-around: 20 sequential uops in mixed-width bundles with the consumer always ready.
    apply(1, 0, 0,0,0, 0,0,0, 0);
    idx = 0; popped = 0; cyc = 0;
    while (popped < 20 && cyc < 200) begin
      if (issue_valid) begin
        chk("wrap_order", issue_uop, 32'(popped));
        popped++;
      end
      w = (cyc % 3 == 0) ? 1 : 2;
      if (20 - idx < w) w = 20 - idx;
      if (w == 2)      apply(0, 0, 1,ST,32'(idx), 1,ST,32'(idx+1), 1);
      else if (w == 1) apply(0, 0, 1,ST,32'(idx), 0,0,0, 1);
      else             apply(0, 0, 0,0,0, 0,0,0, 1);
      if (!mq.size() && 0) ; // no-op guard for readability of loop structure
      if (w > 0 && accept_total == 32'(idx + w)) idx += w;
      cyc++;
    end
    if (popped < 20) begin
      bad++;
      $display("FAIL wrap_timeout: popped %0d of 20", popped);
    end
    chk("wrap_total", accept_total, 20);
    chk("wrap_count", 32'(count), 0);

    // Flush while stalled releases stall and keeps the acceptance count.
    for (int k = 0; k < 4; k++) apply(0, 0, 1,ST,32'h100+k, 1,ST,32'h200+k, 0);
    chk("fs_stall_hi", 32'(stall), 1);
    apply(0, 1, 1,ST,32'h300, 1,ST,32'h301, 1);
    chk("fs_stall_lo", 32'(stall), 0);
    chk("fs_count", 32'(count), 0);
    chk("fs_total", accept_total, 28);

    // Reset while stalled releases stall and clears the acceptance count.
    for (int k = 0; k < 4; k++) apply(0, 0, 1,ST,32'h400+k, 1,ST,32'h500+k, 0);
    chk("rs_stall_hi", 32'(stall), 1);
    apply(1, 1, 1,ST,32'h600, 1,ST,32'h601, 0);
    chk("rs_stall_lo", 32'(stall), 0);
    chk("rs_total", accept_total, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0, smap[$urandom_range(0, 3)], $urandom,
            $urandom_range(0, 3) != 0, smap[$urandom_range(0, 3)], $urandom,
            $urandom_range(0, 2) != 0);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
